// File: rtl/ecc_mul_seq.sv
// ecc_mul_seq: shift-and-add multiplier that borrows the shared 256-bit ALU (ADD/SLL/SRL).
// Latency: result in cycle 3(k+1)+p+2 after the start edge (k = top set bit of b, p = popcount(b)); b=0 -> cycle 2.
// Backpressure: none; i_start is only honoured in IDLE, requests while busy (including DONE) are dropped.
module ecc_mul_seq #(
  parameter int WORD_SIZE = 256,
  parameter int INSN      = 19
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [WORD_SIZE-1:0] i_a,
  input  logic [WORD_SIZE-1:0] i_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [WORD_SIZE-1:0] o_product,
  output logic [INSN:0]        o_alu_insn,
  output logic [WORD_SIZE-1:0] o_alu_r1data,
  output logic [WORD_SIZE-1:0] o_alu_r2data,
  output logic                 o_alu_carry,
  input  logic [WORD_SIZE-1:0] i_alu_result
);

  // Opcode lives in the top five bits; shifts carry a shift amount of 1 in the low nibble.
  localparam logic [INSN:0] ALU_NOP = '0;
  localparam logic [INSN:0] ALU_ADD = (INSN+1)'(5'b00101) << (INSN-4);
  localparam logic [INSN:0] ALU_SLL = ((INSN+1)'(5'b01100) << (INSN-4)) | (INSN+1)'(1);
  localparam logic [INSN:0] ALU_SRL = ((INSN+1)'(5'b01101) << (INSN-4)) | (INSN+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CHK  = 3'd1,
    S_ADD  = 3'd2,
    S_SHL  = 3'd3,
    S_SHR  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t               r_state;
  logic [WORD_SIZE-1:0] r_acc;
  logic [WORD_SIZE-1:0] r_mcand;
  logic [WORD_SIZE-1:0] r_mplier;
  logic                 r_busy;
  logic                 r_done;
  logic [INSN:0]        r_insn;

  // Sequencer: status and instruction word are loaded together with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_insn   <= ALU_NOP;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_busy   <= 1'b1;
            r_insn   <= ALU_NOP;
            r_state  <= S_CHK;
          end
        end
        S_CHK: begin
          // Stop as soon as the remaining multiplier bits are all zero.
          if (r_mplier == '0) begin
            r_done  <= 1'b1;
            r_insn  <= ALU_NOP;
            r_state <= S_DONE;
          end else if (r_mplier[0]) begin
            r_insn  <= ALU_ADD;
            r_state <= S_ADD;
          end else begin
            r_insn  <= ALU_SLL;
            r_state <= S_SHL;
          end
        end
        S_ADD: begin
          r_acc   <= i_alu_result;
          r_insn  <= ALU_SLL;
          r_state <= S_SHL;
        end
        S_SHL: begin
          r_mcand <= i_alu_result;
          r_insn  <= ALU_SRL;
          r_state <= S_SHR;
        end
        S_SHR: begin
          r_mplier <= i_alu_result;
          r_insn   <= ALU_NOP;
          r_state  <= S_CHK;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_insn  <= ALU_NOP;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  logic [WORD_SIZE-1:0] w_r1;
  logic [WORD_SIZE-1:0] w_r2;

  // Operand select from state and working registers only; idle/check/done states drive zeros.
  always_comb begin
    w_r1 = '0;
    w_r2 = '0;
    case (r_state)
      S_ADD: begin
        w_r1 = r_acc;
        w_r2 = r_mcand;
      end
      S_SHL:   w_r1 = r_mcand;
      S_SHR:   w_r1 = r_mplier;
      default: begin
        w_r1 = '0;
        w_r2 = '0;
      end
    endcase
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_product    = r_acc;
  assign o_alu_insn   = r_insn;
  assign o_alu_r1data = w_r1;
  assign o_alu_r2data = w_r2;
  assign o_alu_carry  = 1'b0;

endmodule

// File: tb/tb_ecc_mul_seq.sv
// tb_ecc_mul_seq: directed vectors against ecc_mul_seq with a behavioural ALU beside it.
// Latency: checks exact o_done cycle per operand pair.
// Backpressure: exercises start requests while busy and back-to-back starts.
module tb_ecc_mul_seq;

  localparam int W = 256;
  localparam int INSN = 19;
  localparam logic [INSN:0] OP_NOP = 20'h00000;
  localparam logic [INSN:0] OP_ADD = 20'h28000;
  localparam logic [INSN:0] OP_SHL = 20'h60001;
  localparam logic [INSN:0] OP_SHR = 20'h68001;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_start;
  logic [W-1:0]    i_a, i_b;
  logic            o_busy, o_done;
  logic [W-1:0]    o_product;
  logic [INSN:0]   o_alu_insn;
  logic [W-1:0]    o_alu_r1data, o_alu_r2data;
  logic            o_alu_carry;
  logic [W-1:0]    i_alu_result;

  int n_tests = 0;
  int n_fail  = 0;
  int n_add, n_shl, n_shr, seq_err, rule_err, busy_err;
  logic [INSN:0] prev_insn;

  ecc_mul_seq #(.WORD_SIZE(W), .INSN(INSN)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_a(i_a), .i_b(i_b),
    .o_busy(o_busy), .o_done(o_done), .o_product(o_product),
    .o_alu_insn(o_alu_insn), .o_alu_r1data(o_alu_r1data), .o_alu_r2data(o_alu_r2data),
    .o_alu_carry(o_alu_carry), .i_alu_result(i_alu_result)
  );

  always #5 clk = ~clk;

  // Behavioural shared ALU: add and logical shifts by the low nibble.
  always_comb begin
    i_alu_result = '0;
    case (o_alu_insn[INSN:INSN-4])
      5'b00101: i_alu_result = o_alu_r1data + o_alu_r2data;
      5'b01100: i_alu_result = o_alu_r1data << o_alu_insn[3:0];
      5'b01101: i_alu_result = o_alu_r1data >> o_alu_insn[3:0];
      default:  i_alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    n_add = 0; n_shl = 0; n_shr = 0; seq_err = 0; rule_err = 0; busy_err = 0;
    prev_insn = OP_NOP;
  endtask

  // Per-cycle observation of the ALU drive.
  task automatic observe();
    if (o_alu_insn == OP_ADD) n_add++;
    else if (o_alu_insn == OP_SHL) n_shl++;
    else if (o_alu_insn == OP_SHR) n_shr++;
    else if (o_alu_insn != OP_NOP) rule_err++;
    if (prev_insn == OP_ADD && o_alu_insn != OP_SHL) seq_err++;
    if (prev_insn == OP_SHL && o_alu_insn != OP_SHR) seq_err++;
    if (o_alu_carry !== 1'b0) rule_err++;
    if (o_alu_insn != OP_ADD && o_alu_r2data != '0) rule_err++;
    if (o_alu_insn == OP_NOP && o_alu_r1data != '0) rule_err++;
    prev_insn = o_alu_insn;
  endtask

  // Called at a sample point in an IDLE cycle; start is accepted at the next edge.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_cyc, input logic [W-1:0] exp_prod,
                        input int p1, input int p2, input int p3);
    int cyc;
    int got_cyc;
    logic [W-1:0] prod_at_done;
    i_a = a; i_b = b; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0; i_a = ~a; i_b = ~b;
    cyc = 1; got_cyc = -1; prod_at_done = '0;
    while (cyc <= 1100) begin
      if (cyc == p1 || cyc == p2 || cyc == p3) begin
        i_start = 1'b1; i_a = 256'd9; i_b = 256'd9;
      end else begin
        i_start = 1'b0;
      end
      observe();
      if (o_busy !== 1'b1) busy_err++;
      if (o_done === 1'b1) begin
        got_cyc = cyc;
        prod_at_done = o_product;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".done_cycle"}, 256'(got_cyc), 256'(exp_cyc));
    chk({tag, ".product"}, prod_at_done, exp_prod);
    @(posedge clk); #1;
    i_start = 1'b0;
    chk({tag, ".busy_after"}, 256'(o_busy), 256'd0);
    chk({tag, ".product_held"}, o_product, exp_prod);
  endtask

  initial begin
    int cyc;
    int done_seen;
    rst_n = 1'b0; i_start = 1'b0; i_a = '0; i_b = '0;
    clr_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", 256'(o_busy), 256'd0);
    chk("reset.done", 256'(o_done), 256'd0);
    chk("reset.product", o_product, 256'd0);
    chk("reset.insn", 256'(o_alu_insn), 256'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 3*5: b=101b -> k=2, p=2 -> cycle 13
    clr_stats();
    run_op("mul3x5", 256'd3, 256'd5, 13, 256'd15, -1, -1, -1);
    chk("mul3x5.busy_low", 256'(busy_err), 256'd0);
    chk("mul3x5.adds", 256'(n_add), 256'd2);

    // b=0: no arithmetic instruction ever issued
    clr_stats();
    run_op("bzero", 256'h1234, 256'd0, 2, 256'd0, -1, -1, -1);
    chk("bzero.ops", 256'(n_add + n_shl + n_shr), 256'd0);

    // 2^255 * 2 wraps to 0: k=1, p=1 -> cycle 9
    run_op("wrap", {1'b1, 255'd0}, 256'd2, 9, 256'd0, -1, -1, -1);

    // 1 * (2^256-1): worst case, every iteration ADD,SHL,SHR
    clr_stats();
    run_op("allones", 256'd1, {W{1'b1}}, 1026, {W{1'b1}}, -1, -1, -1);
    chk("allones.adds", 256'(n_add), 256'd256);
    chk("allones.shls", 256'(n_shl), 256'd256);
    chk("allones.shrs", 256'(n_shr), 256'd256);
    chk("allones.sequence", 256'(seq_err), 256'd0);

    // 7*6: b=110b -> k=2, p=2 -> cycle 13; starts in cycles 5, 12 and DONE are ignored
    run_op("overlap", 256'd7, 256'd6, 13, 256'd42, 5, 12, 13);
    // start in first IDLE cycle after DONE: b=1001b -> k=3, p=2 -> cycle 16
    run_op("b2b", 256'd9, 256'd9, 16, 256'd81, -1, -1, -1);

    // abort mid-operation with reset asserted in cycle 10
    i_a = 256'd5; i_b = 256'hFF; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort.acc_before", 256'(o_product != '0), 256'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort.busy", 256'(o_busy), 256'd0);
    chk("abort.done", 256'(o_done), 256'd0);
    chk("abort.product", o_product, 256'd0);
    chk("abort.insn", 256'(o_alu_insn), 256'd0);
    chk("abort.r1", o_alu_r1data, 256'd0);
    chk("abort.r2", o_alu_r2data, 256'd0);
    chk("abort.carry", 256'(o_alu_carry), 256'd0);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (o_done === 1'b1 || o_busy === 1'b1) done_seen++;
    end
    chk("abort.no_done", 256'(done_seen), 256'd0);

    // 2*3 after abort: b=11b -> k=1, p=2 -> cycle 10
    run_op("after_abort", 256'd2, 256'd3, 10, 256'd6, -1, -1, -1);

    chk("drive_rules", 256'(rule_err), 256'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
